buffer_scheduler: RTL and testbench

- Sequences service of the four packet buffers whose per-buffer occupancy counts (3-bit, 0..5 valid entries) come from the combinational counter block.
- Picks one buffer per arbitration, which is the fullest buffer with round-robin tie-break.
- Serves a bounded burst of head entries from it via one-hot pop pulses, pacing each pop against a downstream ready.
- Sits between the buffer bank, the occupancy counter, and the shared output channel.

---
 rtl/buffer_scheduler_pkg.sv | 23 ++
 rtl/buffer_scheduler_pick.sv | 49 ++++
 rtl/buffer_scheduler.sv | 170 +++++++++++++++++
 tb/tb_buffer_scheduler.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_scheduler_pkg.sv
// Shared definitions for the buffer scheduler: FSM state encoding, buffer
// count and occupancy width, plus the occupancy clamp helper.
package buffer_scheduler_pkg;

  localparam int NUM_BUF = 4;
  localparam int MAX_OCC = 5;
  localparam int OCC_W   = 3;

  // Scheduler FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARB    = 2'd1;
  localparam logic [1:0] ST_GRANT  = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  typedef logic [OCC_W-1:0] occ_t;

  // Buffers hold at most MAX_OCC entries; the out-of-range codes 6 and 7
  // are read as a full buffer.
  function automatic occ_t clamp_occ(input occ_t v);
    return (v > occ_t'(MAX_OCC)) ? occ_t'(MAX_OCC) : v;
  endfunction

endpackage

// File: rtl/buffer_scheduler_pick.sv
// buffer_pick: combinational winner selection among the four buffers.
//   occ    : clamped occupancy of each buffer
//   last   : index of the most recently granted buffer
//   aged   : buffers whose starvation age has hit the limit
//   winner : index of the selected buffer
//   found  : at least one buffer is non-empty
// Scan order is round-robin starting at last+1. An aged, non-empty buffer
// overrides occupancy ordering (first aged one in scan order wins);
// otherwise the first buffer in scan order holding the maximum count wins.
module buffer_pick
  import buffer_scheduler_pkg::*;
(
  input  logic [NUM_BUF-1:0][OCC_W-1:0] occ,
  input  logic [1:0]                    last,
  input  logic [NUM_BUF-1:0]            aged,
  output logic [1:0]                    winner,
  output logic                          found
);

  function automatic logic [1:0] rr_idx(input logic [1:0] base, input int k);
    return 2'(int'(base) + k);
  endfunction

  occ_t       best;
  logic [1:0] max_win;
  logic       aged_hit;
  logic [1:0] aged_win;

  always_comb begin
    best     = '0;
    max_win  = '0;
    aged_hit = 1'b0;
    aged_win = '0;
    for (int k = 1; k <= NUM_BUF; k++) begin
      // Strict '>' keeps the earliest buffer in scan order on ties.
      if (occ[rr_idx(last, k)] > best) begin
        best    = occ[rr_idx(last, k)];
        max_win = rr_idx(last, k);
      end
      if (!aged_hit && aged[rr_idx(last, k)] && (occ[rr_idx(last, k)] != '0)) begin
        aged_hit = 1'b1;
        aged_win = rr_idx(last, k);
      end
    end
    found  = (best != '0);
    winner = aged_hit ? aged_win : max_win;
  end

endmodule

// File: rtl/buffer_scheduler.sv
// buffer_scheduler: picks the fullest of four packet buffers (round-robin
// tie-break), then pops up to MAX_BURST head entries from it, one per
// accepted out_ready, with SETTLE_CYCLES of quiet after each pop so the
// occupancy counts can catch up.
//
// Ports:
//   clk, rst_n      : rising-edge clock, synchronous active-low reset
//   en              : scheduler enable
//   L1..L4          : buffer occupancies (0..5; 6/7 read as 5)
//   out_ready       : downstream takes the offered head entry this cycle
//   pop[3:0]        : one-hot single-cycle pop of buffer index+1
//   sel[1:0]        : granted buffer index
//   sel_valid       : a head entry of buffer sel is being offered
//   pkt_count[7:0]  : pops since reset, wrapping
//
// Handshake: a pop happens in the cycle where sel_valid and out_ready are
// both high (with en high and the granted buffer non-empty); sel_valid
// holds with sel stable until that happens or the grant is abandoned.
//
// Build option STARVATION_GUARD_EN: per-buffer age counters; a non-empty
// buffer losing AGE_LIMIT arbitrations is promoted over fuller buffers.
// The FSM state is held in state_q.
module buffer_scheduler
  import buffer_scheduler_pkg::*;
#(
  parameter int MAX_BURST     = 2,
  parameter int SETTLE_CYCLES = 1
`ifdef STARVATION_GUARD_EN
  , parameter int AGE_LIMIT   = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] L1,
  input  logic [2:0] L2,
  input  logic [2:0] L3,
  input  logic [2:0] L4,
  input  logic       out_ready,
  output logic [3:0] pop,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic [7:0] pkt_count
);

  logic [1:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [2:0] burst_q, burst_d;
  logic [7:0] settle_q, settle_d;
  logic [7:0] pkt_q, pkt_d;

  logic [NUM_BUF-1:0][OCC_W-1:0] occ;
  logic [NUM_BUF-1:0]            aged;
  logic [1:0]                    pick_win;
  logic                          pick_found;
  logic                          any_occ;
  logic                          sel_nz;
  logic                          pop_fire;

  assign occ[0]  = clamp_occ(L1);
  assign occ[1]  = clamp_occ(L2);
  assign occ[2]  = clamp_occ(L3);
  assign occ[3]  = clamp_occ(L4);
  assign any_occ = (occ[0] != '0) || (occ[1] != '0) || (occ[2] != '0) || (occ[3] != '0);
  assign sel_nz  = (occ[sel_q] != '0);

  buffer_pick u_pick (
    .occ    (occ),
    .last   (last_q),
    .aged   (aged),
    .winner (pick_win),
    .found  (pick_found)
  );

  assign pop_fire  = (state_q == ST_GRANT) && out_ready && en && sel_nz;
  assign pop       = pop_fire ? 4'(4'b0001 << sel_q) : 4'b0000;
  assign sel       = sel_q;
  assign sel_valid = (state_q == ST_GRANT);
  assign pkt_count = pkt_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    burst_d  = burst_q;
    settle_d = settle_q;
    pkt_d    = pkt_q;
    case (state_q)
      ST_IDLE: begin
        if (en && any_occ) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (pick_found) begin
          sel_d   = pick_win;
          burst_d = '0;
          state_d = ST_GRANT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (!sel_nz) begin
          state_d = ST_ARB;
        end else if (out_ready) begin
          pkt_d    = pkt_q + 8'd1;
          burst_d  = burst_q + 3'd1;
          last_d   = sel_q;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      default: begin // ST_SETTLE: runs its full length even if en drops
        if (settle_q == 8'(SETTLE_CYCLES - 1)) begin
          if ((int'(burst_q) < MAX_BURST) && en && sel_nz) state_d = ST_GRANT;
          else if (en && any_occ)                          state_d = ST_ARB;
          else                                             state_d = ST_IDLE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      last_q   <= 2'd3;  // buffer 0 leads the first tie
      burst_q  <= '0;
      settle_q <= '0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      settle_q <= settle_d;
      pkt_q    <= pkt_d;
    end
  end

`ifdef STARVATION_GUARD_EN
  logic [NUM_BUF-1:0][2:0] age_q, age_d;

  // Ages move only on a successful arbitration: the winner resets, every
  // other non-empty buffer counts one more loss (saturating at 7).
  always_comb begin
    aged  = '0;
    age_d = age_q;
    for (int i = 0; i < NUM_BUF; i++) begin
      aged[i] = (int'(age_q[i]) >= AGE_LIMIT);
      if ((state_q == ST_ARB) && pick_found) begin
        if (2'(i) == pick_win)                          age_d[i] = '0;
        else if ((occ[i] != '0) && (age_q[i] != 3'd7)) age_d[i] = age_q[i] + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) age_q <= '0;
    else        age_q <= age_d;
  end
`else
  assign aged = '0;
`endif

endmodule

// File: tb/tb_buffer_scheduler.sv
// Directed bench for buffer_scheduler. dut_a uses MAX_BURST=2, dut_b uses
// MAX_BURST=1; both share the same stimulus. Inputs change at the falling
// edge, outputs are checked at the falling edge.
module tb_buffer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       out_ready;
  logic [2:0] lv [4];

  logic [3:0] pop_a, pop_b;
  logic [1:0] sel_a, sel_b;
  logic       sv_a, sv_b;
  logic [7:0] pkt_a, pkt_b;

  int n_checks = 0;
  int n_errors = 0;
  logic drain_a;           // bench buffer model: pops from dut_a drain lv
  logic [1:0] exp_q[$];    // expected grant order for dut_b

  always #5 clk = ~clk;

  buffer_scheduler #(.MAX_BURST(2), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en),
    .L1(lv[0]), .L2(lv[1]), .L3(lv[2]), .L4(lv[3]),
    .out_ready(out_ready), .pop(pop_a), .sel(sel_a),
    .sel_valid(sv_a), .pkt_count(pkt_a)
  );

  buffer_scheduler #(.MAX_BURST(1), .SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en),
    .L1(lv[0]), .L2(lv[1]), .L3(lv[2]), .L4(lv[3]),
    .out_ready(out_ready), .pop(pop_b), .sel(sel_b),
    .sel_valid(sv_b), .pkt_count(pkt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One clock: sample pop with inputs final, let the edge happen, drain the
  // modelled buffer, land on the next falling edge.
  task automatic cycle();
    logic [3:0] p;
    #1;
    p = drain_a ? pop_a : 4'b0000;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (p[i] && lv[i] != 3'd0) lv[i] = lv[i] - 3'd1;
    @(negedge clk);
  endtask

  task automatic set_l(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] c, input logic [2:0] d);
    lv[0] = a; lv[1] = b; lv[2] = c; lv[3] = d;
  endtask

  task automatic do_reset();
    drain_a   = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
    set_l(0, 0, 0, 0);
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Run dut_b until every queued grant has been seen, bounded in cycles.
  task automatic run_grants_b(input string tag);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      cycle();
      if (pop_b != 4'b0000) begin
        check_eq(tag, 32'(sel_b), 32'(exp_q.pop_front()));
        check_eq({tag, "_onehot"}, 32'(pop_b), 32'(4'b0001 << sel_b));
      end
    end
    check_eq({tag, "_timeout_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Reset state
    check_eq("rst_sel_valid", 32'(sv_a), 32'd0);
    check_eq("rst_pop", 32'(pop_a), 32'd0);
    check_eq("rst_pkt", 32'(pkt_a), 32'd0);
    check_eq("rst_sel", 32'(sel_a), 32'd0);

    // All empty with en: stays idle
    en = 1'b1;
    cycle(); cycle(); cycle();
    check_eq("empty_sel_valid", 32'(sv_a), 32'd0);
    check_eq("empty_pop", 32'(pop_a), 32'd0);
    check_eq("empty_pkt", 32'(pkt_a), 32'd0);

    // Burst of 2 from the fullest buffer (index 1), draining 4->3->2
    set_l(1, 4, 2, 0);
    out_ready = 1'b1;
    drain_a   = 1'b1;
    cycle();
    check_eq("b_arb_sv", 32'(sv_a), 32'd0);
    cycle();
    check_eq("b_g1_sel", 32'(sel_a), 32'd1);
    check_eq("b_g1_sv", 32'(sv_a), 32'd1);
    check_eq("b_g1_pop", 32'(pop_a), 32'b0010);
    cycle();
    check_eq("b_s1_pop", 32'(pop_a), 32'd0);
    check_eq("b_s1_sv", 32'(sv_a), 32'd0);
    check_eq("b_s1_pkt", 32'(pkt_a), 32'd1);
    cycle();
    check_eq("b_g2_pop", 32'(pop_a), 32'b0010);
    cycle();
    check_eq("b_s2_pkt", 32'(pkt_a), 32'd2);
    cycle();
    check_eq("b_arb2_sv", 32'(sv_a), 32'd0);
    cycle();
    // L=(1,2,2,0), last=1: scan 2,3,0,1 -> first maximum is index 2
    check_eq("b_rearb_sel", 32'(sel_a), 32'd2);
    check_eq("b_rearb_sv", 32'(sv_a), 32'd1);
    en = 1'b0;
    #1;
    check_eq("b_en_off_pop", 32'(pop_a), 32'd0);
    drain_a = 1'b0;
    cycle();
    check_eq("b_en_off_idle", 32'(sv_a), 32'd0);
    check_eq("b_en_off_pkt", 32'(pkt_a), 32'd2);

    // Equal counts, MAX_BURST=1: round-robin 0,1,2,3,0
    do_reset();
    set_l(3, 3, 3, 3);
    en = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    run_grants_b("rr");

    // Grant held while out_ready is low, one pop when it rises
    do_reset();
    set_l(0, 0, 2, 0);
    en = 1'b1;
    cycle(); cycle();
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_sv", 32'(sv_a), 32'd1);
      check_eq("hold_pop", 32'(pop_a), 32'd0);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    check_eq("hold_ready_pop", 32'(pop_a), 32'b0100);
    check_eq("hold_ready_sv", 32'(sv_a), 32'd1);
    cycle();
    out_ready = 1'b0;
    check_eq("hold_after_pkt", 32'(pkt_a), 32'd1);
    check_eq("hold_after_pop", 32'(pop_a), 32'd0);
    cycle();
    check_eq("hold_regrant_sv", 32'(sv_a), 32'd1);
    check_eq("hold_regrant_pop", 32'(pop_a), 32'd0);
    check_eq("hold_regrant_pkt", 32'(pkt_a), 32'd1);

    // Clamp 7->5 ties with buffer 0; emptied grant goes back to ARB
    do_reset();
    set_l(5, 7, 0, 0);
    en = 1'b1;
    cycle(); cycle();
    check_eq("clamp_sel", 32'(sel_a), 32'd0);
    lv[0] = 3'd0;
    out_ready = 1'b1;
    #1;
    check_eq("empty_grant_pop", 32'(pop_a), 32'd0);
    cycle();
    check_eq("empty_grant_arb_sv", 32'(sv_a), 32'd0);
    cycle();
    check_eq("empty_grant_newsel", 32'(sel_a), 32'd1);
    check_eq("empty_grant_newpop", 32'(pop_a), 32'b0010);
    en = 1'b0;
    cycle();
    check_eq("empty_grant_pkt", 32'(pkt_a), 32'd0);

    // Reset during SETTLE with pkt_count=9, then tie goes to buffer 0
    do_reset();
    set_l(0, 5, 0, 0);
    en = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && pkt_a != 8'd9; c++) cycle();
    check_eq("mid_rst_pkt_before", 32'(pkt_a), 32'd9);
    check_eq("mid_rst_in_settle", 32'(sv_a), 32'd0);
    rst_n = 1'b0;
    cycle();
    check_eq("mid_rst_pkt", 32'(pkt_a), 32'd0);
    check_eq("mid_rst_pop", 32'(pop_a), 32'd0);
    check_eq("mid_rst_sv", 32'(sv_a), 32'd0);
    rst_n = 1'b1;
    set_l(2, 2, 2, 2);
    cycle(); cycle();
    check_eq("mid_rst_tie_sel", 32'(sel_a), 32'd0);
    check_eq("mid_rst_tie_sv", 32'(sv_a), 32'd1);

    // Starvation: L=(5,1,0,0), MAX_BURST=1
    do_reset();
    set_l(5, 1, 0, 0);
    en = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(2'd0); exp_q.push_back(2'd0); exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
`ifdef STARVATION_GUARD_EN
    exp_q.push_back(2'd1);
`else
    exp_q.push_back(2'd0);
`endif
    run_grants_b("starve");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
